// File: rtl/stage_four_pkg.sv
// Shared types for the write-back stage: instruction word, opcode and memory-control bundle.
package stage_four_pkg;

   localparam int REG_ADDR_W = 4;

   typedef logic [15:0] uword;

   localparam uword NOP_INSTR = 16'h0000;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_MUL = 4'h3,
      OP_DIV = 4'h4,
      OP_LD  = 4'h5,
      OP_ST  = 4'h6,
      OP_BR  = 4'h7
   } opcode_t;

   typedef struct packed {
      logic regwr;
      logic mem_rd;
      logic mem_wr;
   } memc_t;

   // Destination register field of an instruction word.
   function automatic logic [REG_ADDR_W-1:0] dest_of(input uword instr);
      return instr[11:8];
   endfunction

endpackage

// File: rtl/stage_four_if.sv
// Memory-stage to write-back bundle; the memory stage drives it, the write-back stage consumes it.
interface stage_four_if #(
   parameter int DATA_W = 16
);
   import stage_four_pkg::*;

   logic                  in_valid;
   logic [2*DATA_W-1:0]   data;
   memc_t                 memc;
   logic                  r0_en;
   uword                  instruction;

   modport master (output in_valid, data, memc, r0_en, instruction);
   modport slave  (input  in_valid, data, memc, r0_en, instruction);

endinterface

// File: rtl/stage_four_reg_file.sv
// Architectural register file: two combinational read ports with same-cycle bypass,
// one general write port and a dedicated R0 high-half port that wins on conflict.
module reg_file
   import stage_four_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 16,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     rd_addr_a_i,
   input  logic [AW-1:0]     rd_addr_b_i,
   output logic [DATA_W-1:0] rd_data_a_o,
   output logic [DATA_W-1:0] rd_data_b_o,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              hi_en_i,
   input  logic [DATA_W-1:0] hi_data_i
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         if (wr_en_i) regs_q[wr_addr_i] <= wr_data_i;
         // R0 high half is assigned last so it overrides a same-edge R0 destination write.
         if (hi_en_i) regs_q[0] <= hi_data_i;
      end
   end

   always_comb begin
      rd_data_a_o = regs_q[rd_addr_a_i];
      if (wr_en_i && (wr_addr_i == rd_addr_a_i)) rd_data_a_o = wr_data_i;
      if (hi_en_i && (rd_addr_a_i == '0))        rd_data_a_o = hi_data_i;

      rd_data_b_o = regs_q[rd_addr_b_i];
      if (wr_en_i && (wr_addr_i == rd_addr_b_i)) rd_data_b_o = wr_data_i;
      if (hi_en_i && (rd_addr_b_i == '0))        rd_data_b_o = hi_data_i;
   end

endmodule

// File: rtl/stage_four.sv
// Write-back stage: MEM/WB pipeline register, write-back control and forwarding tap.
// Optional retired-instruction counter enabled by defining STAGE_FOUR_PERF_EN.
module stage_four
   import stage_four_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef STAGE_FOUR_PERF_EN
   output logic [31:0]           retired_count,
`endif
   stage_four_if.slave           mem_i,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  halt_sys,
   input  logic [REG_ADDR_W-1:0] rd_addr_a,
   input  logic [REG_ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0]     rd_data_a,
   output logic [DATA_W-1:0]     rd_data_b,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_dest,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  wb_r0_en,
   output logic [DATA_W-1:0]     wb_r0_data,
   output uword                  instruction_out
);

   logic                valid_q,   valid_d;
   logic [2*DATA_W-1:0] data_q,    data_d;
   logic                regwr_q,   regwr_d;
   logic                r0_en_q,   r0_en_d;
   uword                instr_q,   instr_d;
   logic                written_q, written_d;
   logic                commit;

   // An entry commits exactly once: on the first unhalted edge it spends in MEM/WB.
   assign commit = valid_q && !written_q && !halt_sys;

   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      regwr_d   = regwr_q;
      r0_en_d   = r0_en_q;
      instr_d   = instr_q;
      written_d = written_q;
      if (!halt_sys) begin
         if (commit) written_d = 1'b1;
         if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
         end else if (!stall) begin
            valid_d   = mem_i.in_valid;
            data_d    = mem_i.data;
            regwr_d   = mem_i.memc.regwr;
            r0_en_d   = mem_i.r0_en;
            instr_d   = mem_i.instruction;
            written_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         regwr_q   <= 1'b0;
         r0_en_q   <= 1'b0;
         instr_q   <= NOP_INSTR;
         written_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         regwr_q   <= regwr_d;
         r0_en_q   <= r0_en_d;
         instr_q   <= instr_d;
         written_q <= written_d;
      end
   end

   reg_file #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
   ) u_reg_file (
      .clk         (clk),
      .rst         (rst),
      .rd_addr_a_i (rd_addr_a),
      .rd_addr_b_i (rd_addr_b),
      .rd_data_a_o (rd_data_a),
      .rd_data_b_o (rd_data_b),
      .wr_en_i     (commit && regwr_q),
      .wr_addr_i   (dest_of(instr_q)),
      .wr_data_i   (data_q[DATA_W-1:0]),
      .hi_en_i     (commit && r0_en_q),
      .hi_data_i   (data_q[2*DATA_W-1:DATA_W])
   );

   assign wb_valid        = valid_q && regwr_q && !written_q;
   assign wb_dest         = dest_of(instr_q);
   assign wb_data         = data_q[DATA_W-1:0];
   assign wb_r0_en        = valid_q && r0_en_q && !written_q;
   assign wb_r0_data      = data_q[2*DATA_W-1:DATA_W];
   assign instruction_out = instr_q;

`ifdef STAGE_FOUR_PERF_EN
   logic [31:0] retired_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        retired_q <= '0;
      else if (commit) retired_q <= retired_q + 32'd1;
   end

   assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_stage_four.sv
// Self-checking bench for stage_four: directed scenarios plus a randomized run against
// a transaction-level model of MEM/WB occupancy and the architectural register file.
module tb_stage_four;
   import stage_four_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, halt_sys = 1'b0;
   logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
   logic [15:0] rd_data_a, rd_data_b;
   logic        wb_valid, wb_r0_en;
   logic [3:0]  wb_dest;
   logic [15:0] wb_data, wb_r0_data;
   uword        instruction_out;
`ifdef STAGE_FOUR_PERF_EN
   logic [31:0] retired_count;
`endif

   int errors = 0;
   int checks = 0;

   // Model: architectural registers plus the single MEM/WB slot.
   logic [15:0] m_regs [16];
   logic        m_valid, m_regwr, m_r0, m_done;
   logic [31:0] m_data;
   logic [15:0] m_instr;
   logic [31:0] m_count;

   stage_four_if #(.DATA_W(16)) bus ();

   stage_four dut (
      .clk             (clk),
      .rst             (rst),
`ifdef STAGE_FOUR_PERF_EN
      .retired_count   (retired_count),
`endif
      .mem_i           (bus),
      .stall           (stall),
      .flush           (flush),
      .halt_sys        (halt_sys),
      .rd_addr_a       (rd_addr_a),
      .rd_addr_b       (rd_addr_b),
      .rd_data_a       (rd_data_a),
      .rd_data_b       (rd_data_b),
      .wb_valid        (wb_valid),
      .wb_dest         (wb_dest),
      .wb_data         (wb_data),
      .wb_r0_en        (wb_r0_en),
      .wb_r0_data      (wb_r0_data),
      .instruction_out (instruction_out)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      m_valid = 1'b0; m_regwr = 1'b0; m_r0 = 1'b0; m_done = 1'b0;
      m_data = 32'h0; m_instr = 16'h0; m_count = 32'h0;
   endtask

   // Value a read port should show: stored value, or the value committing this cycle.
   function automatic logic [15:0] exp_rd(input logic [3:0] a, input logic hl);
      logic [15:0] v;
      v = m_regs[a];
      if (!hl && m_valid && !m_done) begin
         if (m_regwr && (m_instr[11:8] == a)) v = m_data[15:0];
         if (m_r0 && (a == 4'd0))             v = m_data[31:16];
      end
      return v;
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic rw, input logic r0,
                        input logic [15:0] ins, input logic st, input logic fl, input logic hl,
                        input logic [3:0] ra, input logic [3:0] rb);
      @(negedge clk);
      bus.in_valid = v; bus.data = d;
      bus.memc.regwr = rw; bus.memc.mem_rd = 1'b0; bus.memc.mem_wr = 1'b0;
      bus.r0_en = r0; bus.instruction = ins;
      stall = st; flush = fl; halt_sys = hl;
      rd_addr_a = ra; rd_addr_b = rb;
      #1;
   endtask

   task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, ra, rb);
   endtask

   // Advance one edge and apply the stage's rules to the model using the inputs in force.
   task automatic tick();
      @(posedge clk);
      if (!halt_sys) begin
         if (m_valid && !m_done) begin
            if (m_regwr) m_regs[m_instr[11:8]] = m_data[15:0];
            if (m_r0)    m_regs[0] = m_data[31:16];
            m_done  = 1'b1;
            m_count = m_count + 32'd1;
         end
         if (flush) begin
            m_valid = 1'b0; m_instr = 16'h0;
         end else if (!stall) begin
            m_valid = bus.in_valid; m_data = bus.data; m_regwr = bus.memc.regwr;
            m_r0 = bus.r0_en; m_instr = bus.instruction; m_done = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.data = '0; bus.memc = '0; bus.r0_en = 1'b0; bus.instruction = '0;
      rst = 1'b0;
      model_reset();
      #12;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
      checks++; if (wb_r0_en !== 1'b0) begin errors++; $display("FAIL reset_wb_r0_en: got %b expected 0", wb_r0_en); end
      checks++; if (instruction_out !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instruction_out); end
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         #1;
         checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0000", i, rd_data_a); end
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic_write();
      drive(1'b1, 32'h0000_1234, 1'b1, 1'b0, 16'h1300, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3);
      checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL basic_before: got %h expected 0000", rd_data_a); end
      tick();
      idle(4'd3, 4'd3);
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL basic_wb_valid: got %b expected 1", wb_valid); end
      checks++; if (wb_dest !== 4'd3) begin errors++; $display("FAIL basic_wb_dest: got %0d expected 3", wb_dest); end
      checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL basic_wb_data: got %h expected 1234", wb_data); end
      tick();
      idle(4'd3, 4'd3);
      checks++; if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL basic_commit: got %h expected 1234", rd_data_a); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_wb_idle: got %b expected 0", wb_valid); end
      tick();
   endtask

   task automatic test_mul_high();
      drive(1'b1, 32'hABCD_0042, 1'b1, 1'b1, 16'h3500, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0);
      tick();
      idle(4'd5, 4'd0);
      checks++; if (wb_r0_en !== 1'b1) begin errors++; $display("FAIL mul_wb_r0_en: got %b expected 1", wb_r0_en); end
      checks++; if (wb_r0_data !== 16'hABCD) begin errors++; $display("FAIL mul_wb_r0_data: got %h expected abcd", wb_r0_data); end
      checks++; if (rd_data_b !== 16'hABCD) begin errors++; $display("FAIL mul_r0_bypass: got %h expected abcd", rd_data_b); end
      tick();
      idle(4'd5, 4'd0);
      checks++; if (rd_data_a !== 16'h0042) begin errors++; $display("FAIL mul_lo: got %h expected 0042", rd_data_a); end
      checks++; if (rd_data_b !== 16'hABCD) begin errors++; $display("FAIL mul_hi: got %h expected abcd", rd_data_b); end
      tick();
      drive(1'b1, 32'h0000_0BAD, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      tick(); idle(4'd0, 4'd0); tick();
      idle(4'd0, 4'd0);
      checks++; if (rd_data_a !== 16'h0BAD) begin errors++; $display("FAIL r0_plain: got %h expected 0bad", rd_data_a); end
      tick();
      drive(1'b1, 32'hABCD_7777, 1'b1, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      tick();
      idle(4'd0, 4'd0);
      checks++; if (rd_data_a !== 16'hABCD) begin errors++; $display("FAIL r0_both_bypass: got %h expected abcd", rd_data_a); end
      tick();
      idle(4'd0, 4'd0);
      checks++; if (rd_data_a !== 16'hABCD) begin errors++; $display("FAIL r0_both_commit: got %h expected abcd", rd_data_a); end
      tick();
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'h0000_00FF, 1'b1, 1'b0, 16'h1700, 1'b0, 1'b0, 1'b0, 4'd7, 4'd7);
      checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL bypass_early: got %h expected 0000", rd_data_a); end
      tick();
      idle(4'd7, 4'd3);
      checks++; if (rd_data_a !== 16'h00FF) begin errors++; $display("FAIL bypass_same_cycle: got %h expected 00ff", rd_data_a); end
      checks++; if (rd_data_b !== 16'h1234) begin errors++; $display("FAIL bypass_other_port: got %h expected 1234", rd_data_b); end
      tick();
   endtask

   task automatic test_stall();
      drive(1'b1, 32'h0000_9999, 1'b1, 1'b0, 16'h1900, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0000_EEEE, 1'b1, 1'b0, 16'h1900, 1'b1, 1'b0, 1'b0, 4'd9, 4'd9);
         checks++; if (wb_valid !== (i == 0)) begin errors++; $display("FAIL stall_wb_valid%0d: got %b expected %b", i, wb_valid, (i == 0)); end
         checks++; if (rd_data_a !== 16'h9999) begin errors++; $display("FAIL stall_rd%0d: got %h expected 9999", i, rd_data_a); end
         tick();
      end
      idle(4'd9, 4'd9);
      checks++; if (rd_data_a !== 16'h9999) begin errors++; $display("FAIL stall_after: got %h expected 9999", rd_data_a); end
      tick();
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h0000_4444, 1'b1, 1'b0, 16'h1400, 1'b0, 1'b0, 1'b0, 4'd4, 4'd10);
      tick();
      drive(1'b1, 32'h0000_8888, 1'b1, 1'b0, 16'h1A00, 1'b1, 1'b1, 1'b0, 4'd4, 4'd10);
      checks++; if (rd_data_a !== 16'h4444) begin errors++; $display("FAIL flush_old_commit: got %h expected 4444", rd_data_a); end
      tick();
      idle(4'd10, 4'd4);
      checks++; if (instruction_out !== 16'h0) begin errors++; $display("FAIL flush_instr: got %h expected 0000", instruction_out); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid: got %b expected 0", wb_valid); end
      tick();
      idle(4'd10, 4'd4);
      checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL flush_no_write: got %h expected 0000", rd_data_a); end
      checks++; if (rd_data_b !== 16'h4444) begin errors++; $display("FAIL flush_reg4: got %h expected 4444", rd_data_b); end
      tick();
   endtask

   task automatic test_halt();
      drive(1'b1, 32'h0000_6666, 1'b1, 1'b0, 16'h1600, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h5555_7777, 1'b1, 1'b1, 16'h3B00, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0);
         checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL halt_reg6_%0d: got %h expected 0000", i, rd_data_a); end
         checks++; if (rd_data_b !== 16'hABCD) begin errors++; $display("FAIL halt_reg0_%0d: got %h expected abcd", i, rd_data_b); end
         checks++; if (instruction_out !== 16'h1600) begin errors++; $display("FAIL halt_instr_%0d: got %h expected 1600", i, instruction_out); end
         tick();
      end
      idle(4'd6, 4'd11);
      checks++; if (rd_data_a !== 16'h6666) begin errors++; $display("FAIL halt_resume: got %h expected 6666", rd_data_a); end
      tick();
      idle(4'd6, 4'd11);
      checks++; if (rd_data_b !== 16'h0) begin errors++; $display("FAIL halt_reg11: got %h expected 0000", rd_data_b); end
      tick();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32'h0000_2222, 1'b1, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
      tick();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL areset_reg2: got %h expected 0000", rd_data_a); end
      checks++; if (rd_data_b !== 16'h0) begin errors++; $display("FAIL areset_reg0: got %h expected 0000", rd_data_b); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL areset_wb_valid: got %b expected 0", wb_valid); end
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
      idle(4'd2, 4'd0);
      tick();
      idle(4'd2, 4'd0);
      checks++; if (rd_data_a !== 16'h0) begin errors++; $display("FAIL areset_no_write: got %h expected 0000", rd_data_a); end
      tick();
   endtask

   task automatic test_random();
      logic v, rw, r0, st, fl, hl;
      logic [3:0] ra, rb;
      for (int n = 0; n < 300; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         rw = $urandom_range(0, 1) == 1;
         r0 = ($urandom_range(0, 3) == 0);
         st = ($urandom_range(0, 6) == 0);
         fl = ($urandom_range(0, 9) == 0);
         hl = ($urandom_range(0, 9) == 0);
         ra = 4'($urandom_range(0, 15));
         rb = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         drive(v, $urandom, rw, r0, 16'($urandom), st, fl, hl, ra, rb);
         checks++; if (rd_data_a !== exp_rd(ra, hl)) begin errors++; $display("FAIL rand_rd_a[%0d]: got %h expected %h", n, rd_data_a, exp_rd(ra, hl)); end
         checks++; if (rd_data_b !== exp_rd(rb, hl)) begin errors++; $display("FAIL rand_rd_b[%0d]: got %h expected %h", n, rd_data_b, exp_rd(rb, hl)); end
         checks++; if (wb_valid !== (m_valid && m_regwr && !m_done)) begin errors++; $display("FAIL rand_wb_valid[%0d]: got %b expected %b", n, wb_valid, (m_valid && m_regwr && !m_done)); end
         checks++; if (wb_r0_en !== (m_valid && m_r0 && !m_done)) begin errors++; $display("FAIL rand_wb_r0_en[%0d]: got %b expected %b", n, wb_r0_en, (m_valid && m_r0 && !m_done)); end
         checks++; if (instruction_out !== m_instr) begin errors++; $display("FAIL rand_instr[%0d]: got %h expected %h", n, instruction_out, m_instr); end
         if (m_valid && m_regwr && !m_done) begin
            checks++; if (wb_dest !== m_instr[11:8] || wb_data !== m_data[15:0]) begin errors++; $display("FAIL rand_wb_fwd[%0d]: got %0d/%h expected %0d/%h", n, wb_dest, wb_data, m_instr[11:8], m_data[15:0]); end
         end
         if (m_valid && m_r0 && !m_done) begin
            checks++; if (wb_r0_data !== m_data[31:16]) begin errors++; $display("FAIL rand_wb_r0_data[%0d]: got %h expected %h", n, wb_r0_data, m_data[31:16]); end
         end
`ifdef STAGE_FOUR_PERF_EN
         checks++; if (retired_count !== m_count) begin errors++; $display("FAIL rand_retired[%0d]: got %0d expected %0d", n, retired_count, m_count); end
`endif
         tick();
      end
      idle(4'd0, 4'd0);
      tick();
   endtask

`ifdef STAGE_FOUR_PERF_EN
   task automatic test_perf();
      logic [6:0] pat;
      pat = 7'b1101011;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         drive(pat[i], $urandom, $urandom_range(0, 1) == 1, 1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
         tick();
      end
      idle(4'd0, 4'd0); tick();
      idle(4'd0, 4'd0); tick();
      idle(4'd0, 4'd0);
      checks++; if (retired_count !== 32'd5) begin errors++; $display("FAIL perf_retired: got %0d expected 5", retired_count); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_write();
      test_mul_high();
      test_bypass();
      test_stall();
      test_flush();
      test_halt();
      test_async_reset();
      test_random();
`ifdef STAGE_FOUR_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
